// File: rtl/router_pkg.sv
// Shared constants, tagged-entry type and header decode for the packet-aware router FIFO.
package router_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int LEN_LSB_DEF = 2;
  localparam int MAX_W       = 64;

  typedef struct packed {
    logic                  hdr;
    logic [DATA_W_DEF-1:0] data;
  } entry_t;

  // Callers zero-extend the header word to MAX_W and truncate the result to their field width.
  function automatic logic [MAX_W-1:0] hdr_len(input logic [MAX_W-1:0] word, input int len_lsb);
    return word >> len_lsb;
  endfunction

endpackage

// File: rtl/router_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module router_fifo_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset so it maps onto RAM; every location is written before it is read.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/router_fifo_pkt.sv
// Packet-aware router output FIFO: tagged storage, occupancy/status flags and per-packet tracking.
module router_fifo_pkt
  import router_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = 16,
  parameter int LEN_LSB   = LEN_LSB_DEF,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int LFD_DELAY = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          soft_rst,
  input  logic                          write_enb,
  input  logic [DATA_W-1:0]             din,
  input  logic                          lfd_state,
  input  logic                          read_enb,
  output logic [DATA_W-1:0]             dout,
  output logic                          dout_valid,
  output logic                          dout_hdr,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_full,
  output logic [$clog2(DEPTH):0]        count,
  output logic [DATA_W-LEN_LSB:0]       rem_cnt,
  output logic                          pkt_end,
  output logic                          pkt_err,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int LEN_W = DATA_W - LEN_LSB;
  localparam int RW    = LEN_W + 1;

  typedef struct packed {
    logic              hdr;
    logic [DATA_W-1:0] data;
  } slot_t;

  logic [PW-1:0]     wr_pt_q, wr_pt_d, rd_pt_q, rd_pt_d;
  logic              lfd_q, hdr_flag, wr_acc, rd_acc;
  logic              byp_q;
  slot_t             byp_slot_q, wr_slot, head;
  logic [DATA_W:0]   ram_rdata;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_hdr_q, dout_hdr_d, dout_valid_q, dout_valid_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic              pkt_end_q, pkt_end_d, pkt_err_q, pkt_err_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;

  assign empty       = (wr_pt_q == rd_pt_q);
  assign full        = (wr_pt_q[AW-1:0] == rd_pt_q[AW-1:0]) && (wr_pt_q[AW] != rd_pt_q[AW]);
  assign count       = wr_pt_q - rd_pt_q;
  assign almost_full = (count >= PW'(AF_THRESH));

  assign hdr_flag = (LFD_DELAY != 0) ? lfd_q : lfd_state;
  assign wr_acc   = write_enb && !full && !soft_rst;
  assign rd_acc   = read_enb && !empty && !soft_rst;
  assign wr_slot  = '{hdr: hdr_flag, data: din};

  // The RAM is read one edge ahead at the next read pointer; a word written into that slot
  // on the same edge is forwarded so the head entry is always current when a read is accepted.
  assign head = byp_q ? byp_slot_q : slot_t'(ram_rdata);
  assign len  = LEN_W'(hdr_len(MAX_W'(head.data), LEN_LSB));

  router_fifo_ram #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_pt_q[AW-1:0]),
    .wr_data_i (wr_slot),
    .rd_addr_i (rd_pt_d[AW-1:0]),
    .rd_data_o (ram_rdata)
  );

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    wr_pt_d      = wr_pt_q;
    rd_pt_d      = rd_pt_q;
    dout_d       = dout_q;
    dout_hdr_d   = dout_hdr_q;
    dout_valid_d = 1'b0;
    rem_d        = rem_q;
    pkt_end_d    = 1'b0;
    pkt_err_d    = 1'b0;
    overflow_d   = write_enb && full;
    underflow_d  = read_enb && empty;
    if (soft_rst) begin
      wr_pt_d     = '0;
      rd_pt_d     = '0;
      dout_d      = '0;
      dout_hdr_d  = 1'b0;
      rem_d       = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_pt_d = wr_pt_q + PW'(1);
      if (rd_acc) begin
        rd_pt_d      = rd_pt_q + PW'(1);
        dout_d       = head.data;
        dout_hdr_d   = head.hdr;
        dout_valid_d = 1'b1;
        if (head.hdr) begin
          rem_d     = {1'b0, len} + RW'(1);
          pkt_err_d = (rem_q != '0);
        end else if (rem_q != '0) begin
          rem_d     = rem_q - RW'(1);
          pkt_end_d = (rem_q == RW'(1));
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_pt_q      <= '0;
      rd_pt_q      <= '0;
      lfd_q        <= 1'b0;
      byp_q        <= 1'b0;
      dout_q       <= '0;
      dout_hdr_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      rem_q        <= '0;
      pkt_end_q    <= 1'b0;
      pkt_err_q    <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_pt_q      <= wr_pt_d;
      rd_pt_q      <= rd_pt_d;
      lfd_q        <= soft_rst ? 1'b0 : lfd_state;
      byp_q        <= wr_acc && (wr_pt_q[AW-1:0] == rd_pt_d[AW-1:0]);
      dout_q       <= dout_d;
      dout_hdr_q   <= dout_hdr_d;
      dout_valid_q <= dout_valid_d;
      rem_q        <= rem_d;
      pkt_end_q    <= pkt_end_d;
      pkt_err_q    <= pkt_err_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    byp_slot_q <= wr_slot;
  end

  assign dout       = dout_q;
  assign dout_hdr   = dout_hdr_q;
  assign dout_valid = dout_valid_q;
  assign rem_cnt    = rem_q;
  assign pkt_end    = pkt_end_q;
  assign pkt_err    = pkt_err_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_router_fifo_pkt.sv
// Self-checking bench: queue scoreboard model on every cycle plus table-driven and hand-written checks.
module tb_router_fifo_pkt;
  import router_pkg::*;

  localparam int DEPTH = 16;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          resetn, soft_rst, write_enb, lfd_state, read_enb;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          dout_valid, dout_hdr, empty, full, almost_full;
  logic [4:0]    count;
  logic [6:0]    rem_cnt;
  logic          pkt_end, pkt_err, overflow, underflow;

  router_fifo_pkt dut (
    .clk         (clk),
    .resetn      (resetn),
    .soft_rst    (soft_rst),
    .write_enb   (write_enb),
    .din         (din),
    .lfd_state   (lfd_state),
    .read_enb    (read_enb),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_hdr    (dout_hdr),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .rem_cnt     (rem_cnt),
    .pkt_end     (pkt_end),
    .pkt_err     (pkt_err),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  entry_t        sb[$];
  logic          m_lfd, m_hdr, m_valid, m_end, m_err, m_ovf, m_unf;
  logic [DW-1:0] m_dout;
  int            m_rem;

  typedef struct {
    logic          w;
    logic [DW-1:0] d;
    logic          l;
    logic          r;
    logic          e_valid;
    logic [DW-1:0] e_dout;
    logic          e_hdr;
    int            e_rem;
    logic          e_end;
    int            e_count;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_lfd = 0; m_hdr = 0; m_valid = 0; m_end = 0; m_err = 0; m_ovf = 0; m_unf = 0;
    m_dout = '0; m_rem = 0;
  endtask

  task automatic model_step();
    entry_t e;
    logic f, em;
    if (soft_rst) begin
      model_reset();
    end else begin
      f  = (sb.size() == DEPTH);
      em = (sb.size() == 0);
      m_ovf = write_enb && f;
      m_unf = read_enb && em;
      m_valid = 0; m_end = 0; m_err = 0;
      if (read_enb && !em) begin
        e = sb.pop_front();
        m_dout = e.data; m_hdr = e.hdr; m_valid = 1;
        if (e.hdr) begin
          m_err = (m_rem != 0);
          m_rem = int'(e.data >> 2) + 1;
        end else if (m_rem != 0) begin
          m_rem--;
          m_end = (m_rem == 0);
        end
      end
      if (write_enb && !f) sb.push_back('{hdr: m_lfd, data: din});
      m_lfd = lfd_state;
    end
  endtask

  task automatic check_all();
    check("count", count, sb.size());
    check("empty", empty, sb.size() == 0);
    check("full", full, sb.size() == DEPTH);
    check("almost_full", almost_full, sb.size() >= DEPTH - 2);
    check("dout_valid", dout_valid, m_valid);
    check("dout", dout, m_dout);
    check("dout_hdr", dout_hdr, m_hdr);
    check("rem_cnt", rem_cnt, m_rem);
    check("pkt_end", pkt_end, m_end);
    check("pkt_err", pkt_err, m_err);
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_unf);
  endtask

  task automatic drive(input logic w, input logic [DW-1:0] d, input logic l, input logic r, input logic s);
    write_enb = w; din = d; lfd_state = l; read_enb = r; soft_rst = s;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 0};
    vecs[1]  = '{1'b1, 8'h0C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1};
    vecs[2]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 2};
    vecs[3]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 3};
    vecs[4]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 4};
    vecs[5]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 5};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h0C, 1'b1, 4, 1'b0, 4};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 3, 1'b0, 3};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 2, 1'b0, 2};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1, 1'b0, 1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hAA, 1'b0, 0, 1'b1, 0};

    resetn = 0; soft_rst = 0; write_enb = 0; lfd_state = 0; read_enb = 0; din = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    resetn = 1;

    // Asynchronous reset in the middle of a cycle with data buffered and dout loaded.
    drive(1, 8'h11, 0, 0, 0);
    drive(1, 8'h22, 0, 0, 0);
    drive(0, 8'h00, 0, 1, 0);
    write_enb = 0; read_enb = 0;
    #3 resetn = 0;
    #1;
    model_reset();
    check("arst_empty", empty, 1);
    check("arst_full", full, 0);
    check("arst_count", count, 0);
    check("arst_dout", dout, 0);
    check("arst_valid", dout_valid, 0);
    check("arst_rem", rem_cnt, 0);
    @(posedge clk);
    #1 resetn = 1;

    // One complete packet, table driven.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].w, vecs[i].d, vecs[i].l, vecs[i].r, 1'b0);
      check("tv_valid", dout_valid, vecs[i].e_valid);
      check("tv_dout", dout, vecs[i].e_dout);
      check("tv_hdr", dout_hdr, vecs[i].e_hdr);
      check("tv_rem", rem_cnt, vecs[i].e_rem);
      check("tv_end", pkt_end, vecs[i].e_end);
      check("tv_count", count, vecs[i].e_count);
    end

    // Fill to full, overflow, then read+write while full.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 8'h80 + DW'(i), 0, 0, 0);
      check("fill_af", almost_full, (i + 1) >= 14);
    end
    check("fill_full", full, 1);
    drive(1, 8'hEE, 0, 0, 0);
    check("ovf_pulse", overflow, 1);
    check("ovf_count", count, 16);
    drive(1, 8'hEF, 0, 1, 0);
    check("rw_full_count", count, 15);
    check("rw_full_dout", dout, 8'h80);
    for (int i = 0; i < DEPTH && sb.size() > 0; i++) drive(0, 8'h00, 0, 1, 0);
    check("drain_last", dout, 8'h8F);

    // Read while empty.
    drive(0, 8'h00, 0, 1, 0);
    check("unf_pulse", underflow, 1);
    check("unf_valid", dout_valid, 0);
    check("unf_dout", dout, 8'h8F);
    check("unf_count", count, 0);

    // Streaming across pointer wrap with constant occupancy.
    for (int i = 0; i < 4; i++) drive(1, 8'h40 + DW'(i), 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      drive(1, 8'h44 + DW'(i), 0, 1, 0);
      check("stream_count", count, 4);
      check("stream_order", dout, 8'h40 + DW'(i));
    end
    for (int i = 0; i < 4; i++) drive(0, 8'h00, 0, 1, 0);

    // Soft reset mid-packet, with competing read and write.
    drive(0, 8'h00, 1, 0, 0);
    drive(1, 8'h10, 0, 0, 0);
    drive(1, 8'h01, 0, 0, 0);
    drive(1, 8'h02, 0, 0, 0);
    drive(0, 8'h00, 0, 1, 0);
    check("pre_srst_rem", rem_cnt, 5);
    drive(0, 8'h00, 0, 1, 0);
    drive(1, 8'h33, 0, 1, 1);
    check("srst_count", count, 0);
    check("srst_empty", empty, 1);
    check("srst_rem", rem_cnt, 0);
    check("srst_dout", dout, 0);

    // Truncated packet: new header while the previous packet still has words outstanding.
    drive(0, 8'h00, 1, 0, 0);
    drive(1, 8'h04, 0, 0, 0);
    drive(1, 8'h01, 1, 0, 0);
    drive(1, 8'h08, 0, 0, 0);
    drive(1, 8'h01, 0, 0, 0);
    drive(0, 8'h00, 0, 1, 0);
    check("trunc_hdr1_rem", rem_cnt, 2);
    drive(0, 8'h00, 0, 1, 0);
    check("trunc_word_rem", rem_cnt, 1);
    drive(0, 8'h00, 0, 1, 0);
    check("trunc_err", pkt_err, 1);
    check("trunc_hdr2_rem", rem_cnt, 3);
    check("trunc_hdr2_flag", dout_hdr, 1);
    drive(0, 8'h00, 0, 1, 0);
    check("trunc_err_clear", pkt_err, 0);
    check("trunc_next_rem", rem_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
